// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - parity mode codes (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - transmitter FSM state encoding (ST_IDLE .. ST_STOP)
//   - frame_cycles(): clock cycles occupied by one complete frame
// No ports; imported by the transmitter top level.
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   // Start bit + data bits + optional parity bit + stop bits, each clk_div long.
   function automatic int frame_cycles(input int data_w, input int parity,
                                       input int stop_bits, input int clk_div);
      return (1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clk_div;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// ----------------------------------------------------------------------------
// uart_fifo
// Synchronous first-word-fall-through FIFO: data_out always shows the head
// entry while empty is low, and rd_en consumes it.
// Ports:
//   clk_sis   in   system clock
//   rst       in   synchronous, active-high reset (pointers and count cleared)
//   wr_en     in   write data_in this cycle (dropped while full)
//   data_in   in   WIDTH-bit word to store
//   rd_en     in   consume the head entry (ignored while empty)
//   data_out  out  head entry
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  entries held
//   overflow  out  registered one-cycle pulse: the previous cycle wrote while full
// ----------------------------------------------------------------------------
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_sis,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             accept;
   logic             pop;

   // full is decoded from the registered count only, so a pop in the same
   // cycle never frees room for a write.
   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign accept   = wr_en && !full;
   assign pop      = rd_en && !empty;
   assign data_out = mem[rd_ptr];

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk_sis) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full;
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the count and pointers
   // already mark every entry invalid, and a reset here would turn RAM into flops.
   always_ff @(posedge clk_sis) begin
      if (accept) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed by a small TX FIFO. Each word is sent as a start bit,
// DATA_W data bits LSB first, an optional parity bit and 1 or 2 stop bits,
// every bit lasting CLK_DIV clock cycles. Frames run back to back while the
// FIFO holds data.
// Ports:
//   clk_sis     in   system clock
//   rst         in   synchronous, active-high reset (aborts frame, flushes FIFO)
//   wr_en       in   write data_in into the FIFO this cycle
//   data_in     in   DATA_W-bit word to transmit
//   full        out  FIFO full; writes while high are dropped
//   overflow    out  one-cycle pulse the cycle after a write was dropped
//   fifo_count  out  entries currently queued
//   tx          out  serial line, idle high
//   busy        out  high from the pop cycle through the last stop bit
//   frame_done  out  one-cycle pulse on the final cycle of the last stop bit
// ----------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 2,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_sis,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             data_in,
   output logic                          full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int            BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   logic [2:0]        state;
   logic [BW-1:0]     baud;
   logic [3:0]        bit_idx;
   logic [DATA_W-1:0] shift;
   logic              par_bit;
   logic [DATA_W-1:0] head;
   logic              empty;
   logic              baud_last;
   logic              stop_done;
   logic              pop;

   uart_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sis  (clk_sis),
      .rst      (rst),
      .wr_en    (wr_en),
      .data_in  (data_in),
      .rd_en    (pop),
      .data_out (head),
      .full     (full),
      .empty    (empty),
      .count    (fifo_count),
      .overflow (overflow)
   );

   assign baud_last  = (baud == BAUD_LAST);
   assign stop_done  = (state == ST_STOP) && baud_last && (bit_idx == STOP_LAST);
   // Pop from IDLE, or on the very last stop cycle so the next start bit
   // follows without an idle gap.
   assign pop        = !empty && ((state == ST_IDLE) || stop_done);
   assign frame_done = stop_done;
   assign busy       = (state != ST_IDLE) || !empty;

   always_ff @(posedge clk_sis) begin
      if (rst) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
      end else begin
         // Parity is fixed at pop time from the whole word, not from the
         // shifting copy.
         if (pop) begin
            shift   <= head;
            par_bit <= (PARITY == PAR_ODD) ? ~^head : ^head;
         end
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state <= ST_START;
                  baud  <= '0;
               end
            end
            ST_START: begin
               if (baud_last) begin
                  state   <= ST_DATA;
                  baud    <= '0;
                  bit_idx <= '0;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_last) begin
                  baud  <= '0;
                  shift <= shift >> 1;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            ST_PAR: begin
               if (baud_last) begin
                  state   <= ST_STOP;
                  baud    <= '0;
                  bit_idx <= '0;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     state   <= pop ? ST_START : ST_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               baud  <= '0;
            end
         endcase
      end
   end

   // NOTE: tx gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      tx = 1'b1;
      case (state)
         ST_START: tx = 1'b0;
         ST_DATA:  tx = shift[0];
         ST_PAR:   tx = par_bit;
         default:  tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Four transmitter instances with different framing share clock and reset:
//   d0: 8N1, CLK_DIV=2     d1: 8E1, CLK_DIV=2
//   d2: 8O1, CLK_DIV=2     d3: 8N2, CLK_DIV=4
// A line monitor per instance decodes frames and checks bit levels and
// frame_done; the main sequence drives directed writes and compares decoded
// frames and status outputs with hand-computed values.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   typedef struct {
      int         sel;
      logic [7:0] word;
      logic       par;
      int         start_cyc;
      int         end_cyc;
   } rec_t;

   logic       clk_sis = 1'b0;
   logic       rst     = 1'b1;
   logic [3:0] wr_v    = '0;
   logic [7:0] data_v [4];
   logic [3:0] full_w, ovf_w, tx_w, busy_w, fd_w;
   logic [2:0] cnt_w [4];

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   rec_t recs[$];

   always #5 clk_sis = ~clk_sis;
   always @(posedge clk_sis) cyc <= cyc + 1;

   uart_tx_fifo #(.DATA_W(8), .CLK_DIV(2), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
      .clk_sis(clk_sis), .rst(rst), .wr_en(wr_v[0]), .data_in(data_v[0]),
      .full(full_w[0]), .overflow(ovf_w[0]), .fifo_count(cnt_w[0]),
      .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
   uart_tx_fifo #(.DATA_W(8), .CLK_DIV(2), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
      .clk_sis(clk_sis), .rst(rst), .wr_en(wr_v[1]), .data_in(data_v[1]),
      .full(full_w[1]), .overflow(ovf_w[1]), .fifo_count(cnt_w[1]),
      .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
   uart_tx_fifo #(.DATA_W(8), .CLK_DIV(2), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
      .clk_sis(clk_sis), .rst(rst), .wr_en(wr_v[2]), .data_in(data_v[2]),
      .full(full_w[2]), .overflow(ovf_w[2]), .fifo_count(cnt_w[2]),
      .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
   uart_tx_fifo #(.DATA_W(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) d3 (
      .clk_sis(clk_sis), .rst(rst), .wr_en(wr_v[3]), .data_in(data_v[3]),
      .full(full_w[3]), .overflow(ovf_w[3]), .fifo_count(cnt_w[3]),
      .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to 1 time unit after the posedge that starts cycle c.
   task automatic drive_at(input int c);
      while (cyc < c) begin
         @(posedge clk_sis);
         #1;
      end
   endtask

   task automatic wait_recs(input int n, input int budget);
      int i = 0;
      while (recs.size() < n && i < budget) begin
         @(negedge clk_sis);
         i++;
      end
      check("frames_seen", recs.size(), n);
   endtask

   task automatic chk_rec(input int i, input int sel, input logic [7:0] w,
                          input int st, input int en);
      if (i >= recs.size()) begin
         check("rec_present", recs.size(), i + 1);
      end else begin
         check($sformatf("rec%0d_sel", i),   recs[i].sel,       sel);
         check($sformatf("rec%0d_word", i),  recs[i].word,      w);
         check($sformatf("rec%0d_start", i), recs[i].start_cyc, st);
         check($sformatf("rec%0d_end", i),   recs[i].end_cyc,   en);
      end
   endtask

   // Line monitor: decodes one frame from the first low level, checks that
   // every bit is held for div cycles, stop levels, and frame_done timing.
   task automatic mon(input int sel, input int div, input int par, input int stopb);
      int         len, b, start;
      logic [7:0] word;
      logic       pb;
      bit         aborted;
      len = (1 + 8 + ((par != 0) ? 1 : 0) + stopb) * div;
      forever begin
         @(negedge clk_sis);
         if (rst !== 1'b0) continue;
         if (tx_w[sel] !== 1'b0) begin
            check($sformatf("d%0d_fd_idle", sel), fd_w[sel], 1'b0);
            continue;
         end
         start   = cyc;
         aborted = 1'b0;
         word    = '0;
         pb      = 1'b0;
         for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk_sis);
            if (rst !== 1'b0) begin
               aborted = 1'b1;
               break;
            end
            b = k / div;
            if (b == 0) begin
               check($sformatf("d%0d_start", sel), tx_w[sel], 1'b0);
            end else if (b <= 8) begin
               if (k % div == 0) word[b-1] = tx_w[sel];
               else check($sformatf("d%0d_hold", sel), tx_w[sel], word[b-1]);
            end else if (par != 0 && b == 9) begin
               if (k % div == 0) pb = tx_w[sel];
               else check($sformatf("d%0d_par_hold", sel), tx_w[sel], pb);
            end else begin
               check($sformatf("d%0d_stop", sel), tx_w[sel], 1'b1);
            end
            check($sformatf("d%0d_fd", sel), fd_w[sel], (k == len - 1));
         end
         if (!aborted) begin
            if (par == 1) check($sformatf("d%0d_par_even", sel), pb, ^word);
            if (par == 2) check($sformatf("d%0d_par_odd", sel), pb, ~^word);
            recs.push_back('{sel, word, pb, start, cyc});
         end
      end
   endtask

   initial mon(0, 2, 0, 1);
   initial mon(1, 2, 1, 1);
   initial mon(2, 2, 2, 1);
   initial mon(3, 4, 0, 2);

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [7:0] wl [6];
      for (int s = 0; s < 4; s++) data_v[s] = '0;

      // Reset values on every instance.
      drive_at(3);
      for (int s = 0; s < 4; s++) begin
         check("rst_tx",       tx_w[s],   1'b1);
         check("rst_busy",     busy_w[s], 1'b0);
         check("rst_full",     full_w[s], 1'b0);
         check("rst_overflow", ovf_w[s],  1'b0);
         check("rst_fd",       fd_w[s],   1'b0);
         check("rst_count",    cnt_w[s],  3'd0);
      end
      rst = 1'b0;

      // 8N1, 0x5B: pop/busy at N+1, start at N+2, frame_done at N+21.
      drive_at(cyc + 1);
      n = cyc;
      wr_v[0] = 1'b1; data_v[0] = 8'h5B;
      drive_at(n + 1);
      wr_v[0] = 1'b0; data_v[0] = 8'hFF;
      check("a_count_n1", cnt_w[0], 3'd1);
      check("a_busy_n1",  busy_w[0], 1'b1);
      check("a_tx_n1",    tx_w[0],  1'b1);
      drive_at(n + 2);
      check("a_tx_n2",    tx_w[0],  1'b0);
      wait_recs(1, 40);
      chk_rec(0, 0, 8'h5B, n + 2, n + 21);
      drive_at(n + 22);
      check("a_busy_end", busy_w[0], 1'b0);
      check("a_tx_end",   tx_w[0],   1'b1);

      // Even parity of 0x5B is 1; odd parity of 0x51 is 0; 22-cycle frames.
      drive_at(cyc + 1);
      n = cyc;
      wr_v[1] = 1'b1; data_v[1] = 8'h5B;
      drive_at(n + 1);
      wr_v[1] = 1'b0;
      wr_v[2] = 1'b1; data_v[2] = 8'h51;
      drive_at(n + 2);
      wr_v[2] = 1'b0;
      wait_recs(3, 60);
      chk_rec(1, 1, 8'h5B, n + 2, n + 23);
      chk_rec(2, 2, 8'h51, n + 3, n + 24);
      if (recs.size() >= 3) begin
         check("b_par_even", recs[1].par, 1'b1);
         check("b_par_odd",  recs[2].par, 1'b0);
      end

      // 8N2, CLK_DIV=4: two 44-cycle frames with no gap, 88 cycles total.
      drive_at(cyc + 1);
      n = cyc;
      wr_v[3] = 1'b1; data_v[3] = 8'h51;
      drive_at(n + 1);
      data_v[3] = 8'h5B;
      drive_at(n + 2);
      wr_v[3] = 1'b0;
      wait_recs(5, 120);
      chk_rec(3, 3, 8'h51, n + 2,  n + 45);
      chk_rec(4, 3, 8'h5B, n + 46, n + 89);

      // FIFO fill while a frame is in progress: 4 accepted, 2 dropped,
      // then a write on the cycle after the first pop is accepted.
      wl = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
      drive_at(cyc + 1);
      n = cyc;
      wr_v[0] = 1'b1; data_v[0] = 8'hA5;
      drive_at(n + 1);
      wr_v[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_at(n + 3 + i);
         wr_v[0] = 1'b1; data_v[0] = 8'(8'h11 * (i + 1));
         if (i == 3) begin
            check("d_full_n6",  full_w[0], 1'b0);
            check("d_count_n6", cnt_w[0],  3'd3);
         end
         if (i == 4) begin
            check("d_full_n7",  full_w[0], 1'b1);
            check("d_count_n7", cnt_w[0],  3'd4);
            check("d_ovf_n7",   ovf_w[0],  1'b0);
         end
         if (i == 5) check("d_ovf_n8", ovf_w[0], 1'b1);
      end
      drive_at(n + 9);
      wr_v[0] = 1'b0;
      check("d_ovf_n9",   ovf_w[0], 1'b1);
      check("d_count_n9", cnt_w[0], 3'd4);
      drive_at(n + 10);
      check("d_ovf_n10",  ovf_w[0], 1'b0);
      drive_at(n + 21);
      check("d_full_n21", full_w[0], 1'b1);
      drive_at(n + 22);
      check("d_full_n22", full_w[0], 1'b0);
      wr_v[0] = 1'b1; data_v[0] = 8'h99;
      drive_at(n + 23);
      wr_v[0] = 1'b0;
      check("d_full_n23", full_w[0], 1'b1);
      wait_recs(11, 140);
      for (int i = 0; i < 6; i++) chk_rec(5 + i, 0, wl[i], n + 2 + 20 * i, n + 21 + 20 * i);
      drive_at(n + 122);
      check("d_busy_end",  busy_w[0], 1'b0);
      check("d_count_end", cnt_w[0],  3'd0);

      // Reset mid-DATA with two words queued: frame aborted, FIFO flushed.
      drive_at(cyc + 1);
      n = cyc;
      wr_v[0] = 1'b1; data_v[0] = 8'h5B;
      drive_at(n + 1); data_v[0] = 8'h77;
      drive_at(n + 2); data_v[0] = 8'h88;
      drive_at(n + 3); wr_v[0] = 1'b0;
      drive_at(n + 8);
      check("e_count_pre", cnt_w[0], 3'd2);
      rst = 1'b1;
      drive_at(n + 9);
      rst = 1'b0;
      check("e_tx",    tx_w[0],   1'b1);
      check("e_count", cnt_w[0],  3'd0);
      check("e_busy",  busy_w[0], 1'b0);
      check("e_fd",    fd_w[0],   1'b0);
      drive_at(n + 60);
      check("e_no_frames", recs.size(), 11);
      check("e_busy_end",  busy_w[0], 1'b0);

      // Write on the frame_done cycle: popped the next cycle, start one later.
      drive_at(cyc + 1);
      n = cyc;
      wr_v[0] = 1'b1; data_v[0] = 8'hC3;
      drive_at(n + 1);
      wr_v[0] = 1'b0;
      drive_at(n + 21);
      check("f_fd_n21", fd_w[0], 1'b1);
      wr_v[0] = 1'b1; data_v[0] = 8'h3C;
      drive_at(n + 22);
      wr_v[0] = 1'b0;
      check("f_count_n22", cnt_w[0],  3'd1);
      check("f_busy_n22",  busy_w[0], 1'b1);
      check("f_tx_n22",    tx_w[0],   1'b1);
      drive_at(n + 23);
      check("f_tx_n23",    tx_w[0],   1'b0);
      wait_recs(13, 60);
      chk_rec(11, 0, 8'hC3, n + 2,  n + 21);
      chk_rec(12, 0, 8'h3C, n + 23, n + 42);

      drive_at(cyc + 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter and the successor to the fixed 8-bit framing path. Host writes words into a small TX FIFO. The block serialises each word as: start bit, DATA_W data bits LSB first, optional parity bit, then 1 or 2 stop bits. Runs on the system clock; the bit period is set by an internal divider. It sits between the system-side producer and the UART line to the receiving UART.

Parameters:
DATA_W, 8, data bits per frame (5..9)
CLK_DIV, 2, clk_sis cycles per bit period (>=1)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)

Ports:
clk_sis  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  write data_in into FIFO this cycle
data_in  in  DATA_W  word to transmit
full  out  1  FIFO full; writes while high are dropped
overflow  out  1  one-cycle pulse when wr_en is asserted while full
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held
tx  out  1  serial line, idle high
busy  out  1  high from pop through end of last stop bit
frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit

Behaviour:
- Clock and reset: one clock, clk_sis. rst is synchronous and active-high.
- Reset values: tx=1, busy=0, full=0, overflow=0, frame_done=0, fifo_count=0. FIFO pointers cleared, FSM=IDLE, baud counter=0.
- Reset mid-frame: the frame is aborted and the FIFO is flushed. tx=1 from the cycle after rst is sampled.
- FIFO write: accepted when wr_en && !full. full is decoded from the registered count only.
  - A write while full is dropped and pulses overflow, even if a pop occurs in the same cycle.
  - Write and pop in the same cycle (not full): count is unchanged and both take effect.
- FIFO is first-word-fall-through internally. Order is preserved.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if fifo_count!=0, pop the head into the shift register, set busy=1, go to START.
  - START: tx=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles, then shift right.
    - After DATA_W bits: go to PAR if PARITY!=0, else STOP.
  - PAR: tx=^data (even) or ~^data (odd), for CLK_DIV cycles. Parity is computed over the popped word.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles. frame_done pulses on the last cycle.
    - Next state is START (immediate pop, no idle gap) if the FIFO is non-empty, else IDLE with busy=0.
- Baud counter: counts 0..CLK_DIV-1. Every bit advances when the count reaches CLK_DIV-1. Cleared on each state entry.
- Latency: wr_en at cycle N into an empty FIFO while IDLE:
  - fifo_count=1 at N+1;
  - pop and busy=1 at N+1;
  - tx=0 from N+2.
- Frame length: (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
- Back-to-back frames: no idle cycles between consecutive frames while the FIFO is non-empty.
- data_in is sampled only on an accepted write. Later changes to data_in do not affect queued words.
- Wrap-around: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. count distinguishes full from empty.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state encoding (IDLE..STOP);
  - a frame-length helper function.
- One sub-module: uart_fifo, a synchronous FIFO with parameters WIDTH and DEPTH and ports wr_en/rd_en/full/empty/count/overflow. The top block holds the FSM, baud counter, shift register and parity.

Test Plan:
- Default params. Write 8'h5B once -> from N+2, tx = 0,1,1,0,1,1,0,1,0,1, each level held 2 cycles. frame_done pulses at cycle N+21, then busy=0 and tx=1.
- PARITY=1. Write 8'h5B -> parity bit 1 after the data bits. PARITY=2 with 8'h51 -> parity bit 0. Frame is 11 bits (22 cycles).
- STOP_BITS=2, CLK_DIV=4. Write 8'h51 then 8'h5B in consecutive cycles -> stop held 8 cycles, then the second start bit follows immediately. Total 2*11*4=88 cycles with no idle gap.
- FIFO_DEPTH=4, tx stalled mid-frame. Write 6 words back-to-back -> full=1 after 4 accepted. overflow pulses on write 6, and on write 5 if no pop has occurred yet. Transmitted words match the accepted ones in order.
- Assert rst for 1 cycle mid-DATA of 8'h5B with 2 words queued -> next cycle tx=1, fifo_count=0, busy=0. No frame_done pulse; no further frames transmitted.
- Write exactly on the frame_done cycle of the previous frame -> new word is popped the following cycle, and no write is lost at the full boundary.
